// File: rtl/pc_unit.sv
// pc_unit: program counter for a simple in-order fetch stage.
//
// Keeps the current fetch PC and moves it on every clock edge. In priority
// order it takes a trap, a branch/jump redirect, a halt request, a stall,
// or the sequential increment. A redirect whose target breaks the alignment
// rule goes to the trap handler instead, and the bad target is recorded.
//
// Ports:
//   clk_i               rising-edge clock
//   rst_ni              asynchronous active-low reset
//   stall_i             hold the current PC this cycle
//   redirect_i          branch/jump taken; load redirect_target_i
//   redirect_target_i   branch/jump destination
//   trap_i              exception/interrupt; load trap_base_i
//   trap_base_i         trap handler base address
//   halt_i              request to enter HALT
//   resume_i            request to leave HALT
//   pc_o                current PC (registered)
//   pc_plus_o           pc_o + INC (combinational, wraps)
//   pc_valid_o          pc_o is fetchable this cycle (state is RUN)
//   misaligned_o        one-cycle pulse after a misaligned redirect
//   misaligned_addr_o   most recent misaligned redirect target
//   issue_count_o       number of cycles with pc_valid_o=1 and stall_i=0
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              INC          = 4,
  parameter int              ALIGN        = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_base_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] misaligned_addr_o,
  output logic [XLEN-1:0] issue_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Ones in the low ALIGN bit positions; these bits must be zero on any loaded PC.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;
  logic [XLEN-1:0] count_q, count_d;

  logic [XLEN-1:0] trap_target;
  logic            target_bad;
  logic            issue;

  assign trap_target = trap_base_i & ~ALIGN_MASK;
  assign target_bad  = (redirect_target_i & ALIGN_MASK) != '0;
  assign issue       = (state_q == RUN) && !stall_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      mis_addr_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      mis_addr_q   <= mis_addr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    mis_addr_d   = mis_addr_q;
    // The count reflects the cycle just ending, whatever happens to the PC.
    count_d      = count_q + XLEN'(issue);

    unique case (state_q)
      // BOOT ignores all inputs; the reset vector becomes the first valid PC.
      BOOT: state_d = RUN;

      RUN: begin
        if (trap_i) begin
          pc_d = trap_target;
        end else if (redirect_i) begin
          if (target_bad) begin
            pc_d         = trap_target;
            misaligned_d = 1'b1;
            mis_addr_d   = redirect_target_i;
          end else begin
            pc_d = redirect_target_i;
          end
        end else if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          pc_d = pc_q + INC_V;
        end
      end

      HALT: begin
        if (trap_i) begin
          state_d = RUN;
          pc_d    = trap_target;
        end else if (resume_i) begin
          state_d = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  assign pc_o              = pc_q;
  assign pc_plus_o         = pc_q + INC_V;
  assign pc_valid_o        = (state_q == RUN);
  assign misaligned_o      = misaligned_q;
  assign misaligned_addr_o = mis_addr_q;
  assign issue_count_o     = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven bench for pc_unit with default parameters.
// Each record holds the inputs for one clock cycle and the outputs expected
// just after the following rising edge. Reset corner cases are hand-written.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, trap, halt, resume;
  logic [31:0] target, trapBase;
  logic [31:0] pcOut, pcPlus, misAddr, issueCount;
  logic        pcValid, misaligned;

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        trap;
    logic [31:0] base;
    logic        halt;
    logic        resume;
    logic [31:0] ePc;
    logic        eValid;
    logic        eMis;
    logic [31:0] eAddr;
    logic [31:0] eCount;
  } vec_t;

  vec_t vecs[$];

  pc_unit dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stall_i           (stall),
    .redirect_i        (redirect),
    .redirect_target_i (target),
    .trap_i            (trap),
    .trap_base_i       (trapBase),
    .halt_i            (halt),
    .resume_i          (resume),
    .pc_o              (pcOut),
    .pc_plus_o         (pcPlus),
    .pc_valid_o        (pcValid),
    .misaligned_o      (misaligned),
    .misaligned_addr_o (misAddr),
    .issue_count_o     (issueCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic rd, logic [31:0] tg, logic tp,
                              logic [31:0] bs, logic hl, logic rs,
                              logic [31:0] pc, logic vl, logic ms,
                              logic [31:0] ad, logic [31:0] cn);
    vec_t v;
    v.stall = st; v.redirect = rd; v.target = tg; v.trap = tp; v.base = bs;
    v.halt = hl; v.resume = rs; v.ePc = pc; v.eValid = vl; v.eMis = ms;
    v.eAddr = ad; v.eCount = cn;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL vec %0d %s: got 0x%08h, expected 0x%08h", applied, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    stall = v.stall; redirect = v.redirect; target = v.target;
    trap = v.trap; trapBase = v.base; halt = v.halt; resume = v.resume;
  endtask

  task automatic checkOutput(input logic [31:0] ePc, input logic eValid,
                             input logic eMis, input logic [31:0] eAddr,
                             input logic [31:0] eCount);
    logic [31:0] ePlus;
    ePlus = ePc + 32'd4;
    applied++;
    cmp("pc",         pcOut,             ePc);
    cmp("pc_plus",    pcPlus,            ePlus);
    cmp("pc_valid",   {31'd0, pcValid},   {31'd0, eValid});
    cmp("misaligned", {31'd0, misaligned}, {31'd0, eMis});
    cmp("mis_addr",   misAddr,           eAddr);
    cmp("issue_cnt",  issueCount,        eCount);
  endtask

  task automatic idle();
    stall = 0; redirect = 0; target = '0; trap = 0; trapBase = '0; halt = 0; resume = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;

    //        st rd target        tp base          hl rs  ePc           vl ms eAddr         eCount
    vecs.push_back(mk(0,0,32'h0,        1,32'h80,        1,0, 32'h0,        1,0,32'h0,        32'd0));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h4,        1,0,32'h0,        32'd1));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h8,        1,0,32'h0,        32'd2));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'hC,        1,0,32'h0,        32'd3));
    vecs.push_back(mk(0,1,32'h100,      0,32'h0,         0,0, 32'h100,      1,0,32'h0,        32'd4));
    vecs.push_back(mk(1,1,32'h200,      0,32'h0,         0,0, 32'h200,      1,0,32'h0,        32'd4));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,         0,0, 32'h200,      1,0,32'h0,        32'd4));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h204,      1,0,32'h0,        32'd5));
    vecs.push_back(mk(0,1,32'h302,      0,32'h8000_0001, 0,0, 32'h8000_0000,1,1,32'h302,      32'd6));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h8000_0004,1,0,32'h302,      32'd7));
    vecs.push_back(mk(0,1,32'h500,      1,32'h40,        0,0, 32'h40,       1,0,32'h302,      32'd8));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,32'h0,         0,0, 32'hFFFF_FFFC,1,0,32'h302,      32'd9));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h0,        1,0,32'h302,      32'd10));
    vecs.push_back(mk(0,1,32'h20,       0,32'h0,         0,0, 32'h20,       1,0,32'h302,      32'd11));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         1,0, 32'h20,       0,0,32'h302,      32'd12));
    vecs.push_back(mk(0,1,32'h700,      0,32'h0,         0,0, 32'h20,       0,0,32'h302,      32'd12));
    vecs.push_back(mk(1,1,32'h704,      0,32'h0,         1,0, 32'h20,       0,0,32'h302,      32'd12));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,1, 32'h20,       1,0,32'h302,      32'd12));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h24,       1,0,32'h302,      32'd13));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         1,0, 32'h24,       0,0,32'h302,      32'd14));
    vecs.push_back(mk(0,0,32'h0,        1,32'h1003,      0,1, 32'h1000,     1,0,32'h302,      32'd14));
    vecs.push_back(mk(1,0,32'h0,        1,32'h2000,      0,0, 32'h2000,     1,0,32'h302,      32'd14));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,         1,0, 32'h2000,     0,0,32'h302,      32'd14));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,1, 32'h2000,     1,0,32'h302,      32'd14));
    vecs.push_back(mk(0,1,32'h3001,     0,32'h50,        0,0, 32'h50,       1,1,32'h3001,     32'd15));
    vecs.push_back(mk(0,1,32'h4002,     0,32'h60,        0,0, 32'h60,       1,1,32'h4002,     32'd16));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,         0,0, 32'h64,       1,0,32'h4002,     32'd17));

    // Reset held across edges with inputs active: outputs stay at reset values.
    trap = 1; trapBase = 32'h900; redirect = 1; target = 32'h33;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(32'h0, 0, 0, 32'h0, 32'd0);

    // Release between edges; the first vector covers the BOOT edge.
    idle();
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].ePc, vecs[i].eValid, vecs[i].eMis, vecs[i].eAddr, vecs[i].eCount);
    end

    // Enter HALT, then pull reset mid-cycle: effect must be immediate.
    idle();
    halt = 1;
    @(posedge clk);
    #1;
    checkOutput(32'h64, 0, 0, 32'h4002, 32'd18);
    idle();
    resume = 1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(32'h0, 0, 0, 32'h0, 32'd0);

    // Release again and confirm the normal boot sequence restarts.
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(32'h0, 1, 0, 32'h0, 32'd0);
    @(posedge clk);
    #1;
    checkOutput(32'h4, 1, 0, 32'h0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
